// File: rtl/universal_shift_register.sv
// Word-wide enabled storage register with eight-function select: hold, load,
// logical shifts, rotates, clear and invert. True and complemented outputs.
module universal_shift_register #(
  parameter int unsigned    WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_neg,
  output logic             ser_out_l,
  output logic             ser_out_r
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_INV  = 3'b111
  } mode_t;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = q_reg;
    if (e) begin
      case (mode_t'(mode))
        MODE_HOLD: q_next = q_reg;
        MODE_LOAD: q_next = data_in;
        MODE_SHL:  q_next = {q_reg[WIDTH-2:0], ser_in_r};
        MODE_SHR:  q_next = {ser_in_l, q_reg[WIDTH-1:1]};
        MODE_ROL:  q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        MODE_ROR:  q_next = {q_reg[0], q_reg[WIDTH-1:1]};
        // Clear goes to zero, deliberately distinct from the reset value.
        MODE_CLR:  q_next = '0;
        MODE_INV:  q_next = ~q_reg;
        default:   q_next = q_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= RESET_VALUE;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q         = q_reg;
  assign q_neg     = ~q_reg;
  assign ser_out_l = q_reg[WIDTH-1];
  assign ser_out_r = q_reg[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed table-driven bench for universal_shift_register, WIDTH=8,
// RESET_VALUE=8'hA5, plus hand sequences for reset corner cases.
module tb_universal_shift_register;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk;
  logic         clk_run;
  logic         rst;
  logic         e;
  logic [2:0]   mode;
  logic [W-1:0] data_in;
  logic         ser_in_r;
  logic         ser_in_l;
  logic [W-1:0] q;
  logic [W-1:0] q_neg;
  logic         ser_out_l;
  logic         ser_out_r;

  int total;
  int bad;

  typedef struct {
    logic         e;
    logic [2:0]   mode;
    logic [W-1:0] data;
    logic         sr;
    logic         sl;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .e         (e),
    .mode      (mode),
    .data_in   (data_in),
    .ser_in_r  (ser_in_r),
    .ser_in_l  (ser_in_l),
    .q         (q),
    .q_neg     (q_neg),
    .ser_out_l (ser_out_l),
    .ser_out_r (ser_out_r)
  );

  // clock / reset block: clock stays low until clk_run is set
  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [W-1:0] req);
    logic [W-1:0] inv;
    inv = ~req;
    check({name, " q"}, q, req);
    check({name, " q_neg"}, q_neg, inv);
    check({name, " ser_out_l"}, {7'd0, ser_out_l}, {7'd0, req[W-1]});
    check({name, " ser_out_r"}, {7'd0, ser_out_r}, {7'd0, req[0]});
  endtask

  function automatic void add(input logic ev, input logic [2:0] m,
                              input logic [W-1:0] d, input logic sr,
                              input logic sl, input logic [W-1:0] x);
    vec_t v;
    v.e = ev; v.mode = m; v.data = d; v.sr = sr; v.sl = sl; v.exp = x;
    vecs.push_back(v);
  endfunction

  // driver: apply inputs on the falling edge, sample 1 after the rising edge
  task automatic drive(input logic ev, input logic [2:0] m,
                       input logic [W-1:0] d, input logic sr, input logic sl);
    @(negedge clk);
    e = ev; mode = m; data_in = d; ser_in_r = sr; ser_in_l = sl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    clk_run = 1'b0;
    rst = 1'b1;
    e = 1'b0; mode = 3'b000; data_in = '0; ser_in_r = 1'b0; ser_in_l = 1'b0;

    // reset state and hold
    for (int i = 0; i < 3; i++) add(1, 3'b000, 8'h00, 0, 0, 8'hA5);
    // load, then enable low must hold even in load mode and invert mode
    add(1, 3'b001, 8'h3C, 0, 0, 8'h3C);
    for (int i = 0; i < 4; i++) add(0, 3'b001, 8'hFF, 0, 0, 8'h3C);
    add(0, 3'b111, 8'hFF, 1, 1, 8'h3C);
    // shifts from 8'h81
    add(1, 3'b001, 8'h81, 0, 0, 8'h81);
    add(1, 3'b010, 8'hFF, 1, 1, 8'h03);
    add(1, 3'b001, 8'h81, 0, 0, 8'h81);
    add(1, 3'b011, 8'hFF, 1, 0, 8'h40);
    add(1, 3'b001, 8'h81, 0, 0, 8'h81);
    add(1, 3'b011, 8'h00, 0, 1, 8'hC0);
    add(1, 3'b001, 8'h81, 0, 0, 8'h81);
    add(1, 3'b010, 8'h00, 0, 1, 8'h02);
    add(1, 3'b010, 8'h00, 0, 1, 8'h04);
    add(1, 3'b010, 8'h00, 0, 1, 8'h08);
    add(1, 3'b010, 8'h00, 0, 1, 8'h10);
    add(1, 3'b010, 8'h00, 0, 1, 8'h20);
    add(1, 3'b010, 8'h00, 0, 1, 8'h40);
    add(1, 3'b010, 8'h00, 0, 1, 8'h80);
    add(1, 3'b010, 8'h00, 0, 1, 8'h00);
    // rotates from 8'h81
    add(1, 3'b001, 8'h81, 0, 0, 8'h81);
    add(1, 3'b100, 8'h00, 0, 0, 8'h03);
    add(1, 3'b100, 8'h00, 0, 0, 8'h06);
    add(1, 3'b001, 8'h81, 0, 0, 8'h81);
    add(1, 3'b101, 8'h00, 0, 0, 8'hC0);
    add(1, 3'b101, 8'h00, 0, 0, 8'h60);
    add(1, 3'b101, 8'h00, 0, 0, 8'h30);
    add(1, 3'b101, 8'h00, 0, 0, 8'h18);
    add(1, 3'b101, 8'h00, 0, 0, 8'h0C);
    add(1, 3'b101, 8'h00, 0, 0, 8'h06);
    add(1, 3'b101, 8'h00, 0, 0, 8'h03);
    add(1, 3'b101, 8'h00, 0, 0, 8'h81);
    // invert and clear
    add(1, 3'b001, 8'h3C, 0, 0, 8'h3C);
    add(1, 3'b111, 8'h00, 0, 0, 8'hC3);
    add(1, 3'b111, 8'h00, 0, 0, 8'h3C);
    add(1, 3'b110, 8'hFF, 1, 1, 8'h00);
    add(0, 3'b111, 8'hFF, 1, 1, 8'h00);

    // asynchronous reset with the clock idle
    #2 rst = 1'b0;
    #1 check_all("reset idle", 8'hA5);
    #5 rst = 1'b1;
    #2 clk_run = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      // serial out on the left must be visible before the SHL edge
      if (vecs[i].mode == 3'b010 && vecs[i].sr)
        check("ser_out_l before shl", {7'd0, ser_out_l}, 8'h01);
      drive(vecs[i].e, vecs[i].mode, vecs[i].data, vecs[i].sr, vecs[i].sl);
      check_all($sformatf("vec%0d", i), vecs[i].exp);
    end

    // reset in the middle of a shift stream
    drive(1, 3'b001, 8'h3C, 0, 0);
    drive(1, 3'b010, 8'h00, 1, 0);
    check_all("stream shl1", 8'h79);
    drive(1, 3'b010, 8'h00, 1, 0);
    check_all("stream shl2", 8'hF3);
    #2 rst = 1'b0;
    #1 check_all("mid reset", 8'hA5);
    @(posedge clk);
    #1 check_all("reset holds over edge", 8'hA5);
    @(negedge clk);
    rst = 1'b1;
    ser_in_r = 1'b0;
    @(posedge clk);
    #1 check_all("resume shl", 8'h4A);
    drive(1, 3'b010, 8'h00, 1, 0);
    check_all("resume shl2", 8'h95);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised WIDTH-bit register with clock enable and an eight-mode function select: hold, parallel load, logical shift left/right with serial inputs, rotate left/right, synchronous clear and bitwise invert. It generalises the single-bit enabled D flip-flop to a word-wide storage element. It is the shared datapath register for serial/parallel converters and scratch registers in the digital-modules library. True and complemented outputs are both provided, matching the flip-flop's q/q_neg convention.

## Interface
- WIDTH, 8: register width in bits; legal range 2..64.
- RESET_VALUE, {WIDTH{1'b0}}: value forced into the register by reset.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low. rst=0 forces q=RESET_VALUE immediately, independent of clk.
- e  input  1  clock enable; e=0 holds the register regardless of mode.
- mode  input  3  function select; see Operation.
- data_in  input  WIDTH  parallel load word.
- ser_in_r  input  1  serial bit entering at bit 0 on shift left.
- ser_in_l  input  1  serial bit entering at bit WIDTH-1 on shift right.
- q  output  WIDTH  register contents.
- q_neg  output  WIDTH  bitwise complement of q, always equal to ~q, including during reset.
- ser_out_l  output  1  q[WIDTH-1], the bit shifted out on shift left.
- ser_out_r  output  1  q[0], the bit shifted out on shift right.

## Operation
- State: one WIDTH-bit register; all outputs are combinational functions of it.
- On a rising clk edge with rst=1 and e=1, the next value is selected by mode:
  - 000 HOLD: q unchanged.
  - 001 LOAD: q <= data_in.
  - 010 SHL: q <= {q[WIDTH-2:0], ser_in_r}.
  - 011 SHR: q <= {ser_in_l, q[WIDTH-1:1]}.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 CLR: q <= 0. This clears to zero, not to RESET_VALUE.
  - 111 INV: q <= ~q.
- e=0 means hold for every mode. Enable has priority over mode.
- Reset has priority over everything. While rst=0, the clk, e and mode inputs are ignored.
- X or Z on mode with e=1 is a bench error. RTL behaviour in that case is unspecified.

## Timing
- Reset values:
  - q = RESET_VALUE and q_neg = ~RESET_VALUE, asserted asynchronously on the falling edge of rst.
  - ser_out_l = RESET_VALUE[WIDTH-1].
  - ser_out_r = RESET_VALUE[0].
- Reset release: rst rising is synchronised by the user. The first edge that can update q is the first rising clk edge with rst=1.
  - Reset released mid-operation: the register resumes from RESET_VALUE.
  - No shift or load in flight is preserved.
- Latency: one cycle from inputs sampled at edge N to q valid after edge N. There is no extra pipeline.
- q_neg, ser_out_l and ser_out_r track q combinationally, with zero-cycle delay relative to q.
- Inputs must be stable around the rising edge. data_in and the serial inputs are sampled only in the mode that uses them.
- Rotation wrap-around:
  - WIDTH consecutive ROL or ROR cycles return q to its starting value.
  - WIDTH consecutive SHL cycles with ser_in_r=0 yield 0.
- Simultaneous events:
  - rst falling on the same instant as a clk edge: reset wins, q=RESET_VALUE.
  - e toggling with mode: only the values at the edge matter.

## Test plan
All scenarios use WIDTH=8 and RESET_VALUE=8'hA5.
1. Reset: rst=0 with clk idle -> q=8'hA5 and q_neg=8'h5A with no clock edge. Release, keep mode=000 for 3 edges -> q stays 8'hA5.
2. Load and enable: mode=001 with data_in=8'h3C, e=1 -> q=8'h3C after 1 edge. Then e=0 with data_in=8'hFF for 4 edges -> q stays 8'h3C.
3. Shifts from q=8'h81:
   - SHL with ser_in_r=1 -> 8'h03, and ser_out_l was 1 before the edge.
   - SHR with ser_in_l=0 from 8'h81 -> 8'h40.
   - 8 SHL cycles with ser_in_r=0 -> 8'h00.
4. Rotates from q=8'h81:
   - ROL -> 8'h03.
   - ROR from 8'h81 -> 8'hC0.
   - 8 ROR cycles -> 8'h81 restored.
5. CLR and INV:
   - From 8'h3C, INV -> 8'hC3, and q_neg=8'h3C.
   - INV again -> 8'h3C.
   - CLR -> 8'h00, not 8'hA5.
6. Reset mid-operation: a continuous SHL stream is running. Assert rst=0 between edges -> q=8'hA5 immediately. Release -> shifting resumes from 8'hA5 (first SHL with ser_in_r=0 gives 8'h4A).
